// File: rtl/alu_seq.sv
// Registered ALU for the multi-cycle datapath: most ops complete in one cycle, while mul
// iterates shift-add over WIDTH cycles. G, zero and carry hold until the next completion.
module alu_seq #(
   parameter int unsigned WIDTH      = 16,
   parameter bit          SIGNED_SLT = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] Bus,
   output logic [WIDTH-1:0] G,
   output logic             done,
   output logic             busy,
   output logic             zero,
   output logic             carry
);

   localparam int unsigned      CntW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
   localparam logic [CntW-1:0]  LastIter = CntW'(WIDTH - 1);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpOr  = 3'b010;
   localparam logic [2:0] OpSlt = 3'b011;
   localparam logic [2:0] OpSll = 3'b100;
   localparam logic [2:0] OpSrl = 3'b101;
   localparam logic [2:0] OpMul = 3'b110;
   localparam logic [2:0] OpAnd = 3'b111;

   typedef enum logic [0:0] {StIdle, StMul} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     g_q, g_d;
   logic                 done_q, done_d;
   logic                 zero_q, zero_d;
   logic                 carry_q, carry_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic                 lt;
   logic                 shift_oob;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_cy;
   logic [2*WIDTH-1:0]   acc_step;

   // Single-cycle datapath; the extra MSB of diff is the borrow (A < Bus unsigned).
   always_comb begin
      sum       = {1'b0, A} + {1'b0, Bus};
      diff      = {1'b0, A} - {1'b0, Bus};
      lt        = SIGNED_SLT ? ($signed(A) < $signed(Bus)) : (A < Bus);
      shift_oob = (Bus >= WidthVal);
      alu_res   = '0;
      alu_cy    = 1'b0;
      unique case (control)
         OpAdd: begin
            alu_res = sum[WIDTH-1:0];
            alu_cy  = sum[WIDTH];
         end
         OpSub: begin
            alu_res = diff[WIDTH-1:0];
            alu_cy  = diff[WIDTH];
         end
         OpOr:  alu_res = A | Bus;
         OpSlt: alu_res = lt ? WIDTH'(1) : '0;
         OpSll: alu_res = shift_oob ? '0 : (A << Bus);
         OpSrl: alu_res = shift_oob ? '0 : (A >> Bus);
         OpMul: alu_res = '0;
         OpAnd: alu_res = A & Bus;
      endcase
   end

   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      done_d   = 1'b0;
      zero_d   = zero_q;
      carry_d  = carry_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (control == OpMul) begin
                  mcand_d  = {{WIDTH{1'b0}}, A};
                  mplier_d = Bus;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = StMul;
               end else begin
                  g_d     = alu_res;
                  carry_d = alu_cy;
                  zero_d  = (alu_res == '0);
                  done_d  = 1'b1;
               end
            end
         end
         StMul: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == LastIter) begin
               g_d     = acc_step[WIDTH-1:0];
               carry_d = |acc_step[2*WIDTH-1:WIDTH];
               zero_d  = (acc_step[WIDTH-1:0] == '0);
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         g_q      <= '0;
         done_q   <= 1'b0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         done_q   <= done_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign G     = g_q;
   assign done  = done_q;
   assign busy  = (state_q == StMul);
   assign zero  = zero_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq: two instances (unsigned and signed slt) share stimulus,
// expected results are queued at issue and popped by a monitor whenever done is seen.
module tb_alu_seq;

   localparam int unsigned W = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    control = 3'd0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  Bus = '0;

   logic [W-1:0]  g0, g1;
   logic          done0, done1, busy0, busy1, zero0, zero1, carry0, carry1;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic [17:0]   q0[$];
   logic [17:0]   q1[$];
   logic [17:0]   last0 = '0;

   always #5 clock = ~clock;

   alu_seq #(.WIDTH(W), .SIGNED_SLT(1'b0)) dut0 (
      .clock(clock), .reset(reset), .start(start), .control(control), .A(A), .Bus(Bus),
      .G(g0), .done(done0), .busy(busy0), .zero(zero0), .carry(carry0)
   );

   alu_seq #(.WIDTH(W), .SIGNED_SLT(1'b1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .control(control), .A(A), .Bus(Bus),
      .G(g1), .done(done1), .busy(busy1), .zero(zero1), .carry(carry1)
   );

   // Reference: {zero, carry, G} from plain arithmetic on the operands.
   function automatic logic [17:0] model(input logic [2:0] c, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input bit sgn);
      logic [W-1:0] g;
      logic         cy;
      logic [31:0]  p;
      g  = '0;
      cy = 1'b0;
      p  = '0;
      case (c)
         3'd0: begin p = 32'(a) + 32'(b); g = p[15:0]; cy = p[16]; end
         3'd1: begin g = a - b; cy = (a < b); end
         3'd2: g = a | b;
         3'd3: g = (sgn ? ($signed(a) < $signed(b)) : (a < b)) ? 16'd1 : 16'd0;
         3'd4: g = (b >= 16'd16) ? 16'd0 : (a << b);
         3'd5: g = (b >= 16'd16) ? 16'd0 : (a >> b);
         3'd6: begin p = 32'(a) * 32'(b); g = p[15:0]; cy = (p[31:16] != 16'd0); end
         default: g = a & b;
      endcase
      return {(g == 16'd0), cy, g};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (done0) begin
            if (q0.size() == 0) check("done0_unexpected", 32'd1, 32'd0);
            else check("result0", 32'({zero0, carry0, g0}), 32'(q0.pop_front()));
         end
         if (done1) begin
            if (q1.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
            else check("result1", 32'({zero1, carry1, g1}), 32'(q1.pop_front()));
         end
      end
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_done);
      control = c;
      A       = a;
      Bus     = b;
      start   = 1'b1;
      if (expect_done) begin
         q0.push_back(model(c, a, b, 1'b0));
         q1.push_back(model(c, a, b, 1'b1));
         last0 = model(c, a, b, 1'b0);
      end
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done0 && n < 40) begin
         cycle();
         n++;
      end
      if (!done0) check("wait_done_timeout", 32'd0, 32'd1);
   endtask

   // Mul with random start pulses and operand noise while busy; counts busy cycles.
   task automatic mul_timed(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      issue(3'd6, a, b, 1'b1);
      n = 0;
      while (busy0 && n < 40) begin
         start   = 1'($urandom_range(0, 1));
         control = 3'($urandom_range(0, 7));
         A       = 16'($urandom);
         Bus     = 16'($urandom);
         n++;
         cycle();
      end
      start = 1'b0;
      check("mul_busy_cycles", 32'(n), 32'(W));
      check("mul_done_after_busy", 32'(done0), 32'd1);
   endtask

   initial begin
      logic [2:0]   c;
      logic [W-1:0] a, b;

      reset = 1'b1;
      cycle();
      cycle();
      check("reset_g", 32'({g0, g1}), 32'd0);
      check("reset_flags", 32'({done0, busy0, zero0, carry0, done1, busy1, zero1, carry1}),
            32'd0);
      reset = 1'b0;
      cycle();

      issue(3'd0, 16'hFFFF, 16'h0001, 1'b1);
      check("add_done_latency", 32'(done0), 32'd1);
      cycle();
      check("done_one_cycle", 32'(done0), 32'd0);

      issue(3'd1, 16'd3, 16'd5, 1'b1);      cycle();
      issue(3'd3, 16'h8000, 16'd1, 1'b1);   cycle();
      issue(3'd4, 16'h0001, 16'd15, 1'b1);  cycle();
      issue(3'd5, 16'h8000, 16'd16, 1'b1);  cycle();
      issue(3'd4, 16'h1234, 16'hFFFF, 1'b1); cycle();
      issue(3'd7, 16'hF0F0, 16'h3C3C, 1'b1); cycle();
      issue(3'd2, 16'hF0F0, 16'h0F0F, 1'b1); cycle();

      mul_timed(16'd300, 16'd200);
      // Back-to-back: add issued in the mul's done cycle.
      issue(3'd0, 16'h1111, 16'h2222, 1'b1);
      check("b2b_done", 32'(done0), 32'd1);
      cycle();

      mul_timed(16'h0100, 16'h0100);
      repeat (3) cycle();
      check("hold_after_mul", 32'({zero0, carry0, g0}), 32'(last0));

      // Reset during MUL cycle 8: abort with no done pulse.
      issue(3'd6, 16'h00FF, 16'h00FF, 1'b0);
      repeat (7) cycle();
      check("busy_before_abort", 32'(busy0), 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("abort_state", 32'({g0, busy0, done0}), 32'd0);
      repeat (W + 4) cycle();
      issue(3'd0, 16'd40, 16'd2, 1'b1);
      check("add_after_abort", 32'(done0), 32'd1);
      cycle();

      for (int i = 0; i < 150; i++) begin
         c = 3'($urandom_range(0, 7));
         a = 16'($urandom);
         b = 16'($urandom);
         if ((c == 3'd4 || c == 3'd5) && $urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 20));
         if ($urandom_range(0, 7) == 0) b = a;
         issue(c, a, b, 1'b1);
         wait_done();
         if ($urandom_range(0, 1) == 1) cycle();
      end

      repeat (5) cycle();
      check("hold_final", 32'({zero0, carry0, g0}), 32'(last0));
      check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
